// File: rtl/audio_mixer.sv
// Multi-channel stereo mixer: time-multiplexed gain MAC, saturation and I2S-aligned output.
// Define AUDIO_MIXER_PEAK_EN to add the peak_l/peak_r magnitude meters and peak_clear input.
module audio_mixer #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 24,
    parameter int unsigned GAIN_W = 8,
    localparam int unsigned AddrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     next_sample_i,
    input  logic [NUM_CH*IN_W-1:0]   ch_left_i,
    input  logic [NUM_CH*IN_W-1:0]   ch_right_i,
    input  logic [AddrW-1:0]         gain_addr_i,
    input  logic [GAIN_W-1:0]        gain_wrdata_i,
    input  logic                     gain_write_i,
    output logic [GAIN_W-1:0]        gain_rddata_o,
    input  logic                     master_mute_i,
    input  logic                     clip_clear_i,
    output logic [OUT_W-1:0]         left_out_o,
    output logic [OUT_W-1:0]         right_out_o,
    output logic                     out_valid_o,
    output logic                     busy_o,
    output logic                     clip_l_o,
    output logic                     clip_r_o,
`ifdef AUDIO_MIXER_PEAK_EN
    input  logic                     peak_clear_i,
    output logic [OUT_W-2:0]         peak_l_o,
    output logic [OUT_W-2:0]         peak_r_o,
`endif
    output logic                     overrun_o
);

    localparam int unsigned AccW = IN_W + GAIN_W + $clog2(NUM_CH) + 1;
    localparam int unsigned PW   = IN_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] GainUnity = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic signed [AccW-1:0] SatMax = {{(AccW-IN_W){1'b0}}, {IN_W{1'b1}}};
    localparam logic signed [AccW-1:0] SatMin = {{(AccW-IN_W){1'b1}}, {IN_W{1'b0}}};
    localparam logic [AddrW-1:0] LastIdx = AddrW'(NUM_CH - 1);
    localparam logic [AddrW:0]   NumChL  = (AddrW+1)'(NUM_CH);

    typedef enum logic [1:0] {StIdle, StMac, StSat, StOut} state_e;

    state_e state_q, state_d;

    logic [GAIN_W-1:0]        gain_q   [NUM_CH];
    logic signed [IN_W-1:0]   snap_l_q [NUM_CH];
    logic signed [IN_W-1:0]   snap_r_q [NUM_CH];
    logic [AddrW-1:0]         idx_q;
    logic signed [AccW-1:0]   acc_l_q, acc_r_q;
    logic signed [IN_W:0]     sat_l_q, sat_r_q;
    logic signed [OUT_W-1:0]  left_out_q, right_out_q;
    logic                     out_valid_q, clip_l_q, clip_r_q, overrun_q;
    logic                     pend_valid_q;
    logic [AddrW-1:0]         pend_addr_q;
    logic [GAIN_W-1:0]        pend_data_q;

    logic                     addr_ok;
    logic signed [PW-1:0]     gain_ext, prod_l, prod_r;
    logic signed [AccW-1:0]   mix_l, mix_r;
    logic signed [IN_W:0]     sat_l_d, sat_r_d;
    logic                     hit_l, hit_r;
    logic                     clip_set_l, clip_set_r, ovr_set;

    assign addr_ok = {1'b0, gain_addr_i} < NumChL;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (next_sample_i) state_d = StMac;
            StMac:   if (idx_q == LastIdx) state_d = StSat;
            StSat:   state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Gain is unsigned: zero-extend before the signed multiply.
    always_comb begin
        gain_ext = $signed(PW'({1'b0, gain_q[idx_q]}));
        prod_l   = PW'(snap_l_q[idx_q]) * gain_ext;
        prod_r   = PW'(snap_r_q[idx_q]) * gain_ext;
    end

    always_comb begin
        mix_l   = acc_l_q >>> (GAIN_W - 1);
        mix_r   = acc_r_q >>> (GAIN_W - 1);
        sat_l_d = mix_l[IN_W:0];
        sat_r_d = mix_r[IN_W:0];
        hit_l   = 1'b0;
        hit_r   = 1'b0;
        if (mix_l > SatMax) begin
            sat_l_d = SatMax[IN_W:0];
            hit_l   = 1'b1;
        end else if (mix_l < SatMin) begin
            sat_l_d = SatMin[IN_W:0];
            hit_l   = 1'b1;
        end
        if (mix_r > SatMax) begin
            sat_r_d = SatMax[IN_W:0];
            hit_r   = 1'b1;
        end else if (mix_r < SatMin) begin
            sat_r_d = SatMin[IN_W:0];
            hit_r   = 1'b1;
        end
        if (master_mute_i) begin
            sat_l_d = '0;
            sat_r_d = '0;
            hit_l   = 1'b0;
            hit_r   = 1'b0;
        end
    end

    assign clip_set_l = (state_q == StSat) && hit_l;
    assign clip_set_r = (state_q == StSat) && hit_r;
    assign ovr_set    = next_sample_i && (state_q != StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) begin
                gain_q[i]   <= GainUnity;
                snap_l_q[i] <= '0;
                snap_r_q[i] <= '0;
            end
            idx_q        <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            sat_l_q      <= '0;
            sat_r_q      <= '0;
            left_out_q   <= '0;
            right_out_q  <= '0;
            out_valid_q  <= 1'b0;
            clip_l_q     <= 1'b0;
            clip_r_q     <= 1'b0;
            overrun_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            out_valid_q <= (state_q == StOut);
            clip_l_q    <= clip_set_l | (clip_l_q & ~clip_clear_i);
            clip_r_q    <= clip_set_r | (clip_r_q & ~clip_clear_i);
            overrun_q   <= ovr_set | (overrun_q & ~clip_clear_i);
            case (state_q)
                StIdle: begin
                    if (next_sample_i) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            snap_l_q[i] <= ch_left_i[i*IN_W +: IN_W];
                            snap_r_q[i] <= ch_right_i[i*IN_W +: IN_W];
                        end
                        idx_q   <= '0;
                        acc_l_q <= '0;
                        acc_r_q <= '0;
                    end
                    if (gain_write_i && addr_ok) gain_q[gain_addr_i] <= gain_wrdata_i;
                end
                StMac: begin
                    acc_l_q <= acc_l_q + AccW'(prod_l);
                    acc_r_q <= acc_r_q + AccW'(prod_r);
                    idx_q   <= idx_q + AddrW'(1);
                end
                StSat: begin
                    sat_l_q <= sat_l_d;
                    sat_r_q <= sat_r_d;
                end
                StOut: begin
                    left_out_q  <= OUT_W'(sat_l_q) <<< (OUT_W - IN_W - 1);
                    right_out_q <= OUT_W'(sat_r_q) <<< (OUT_W - IN_W - 1);
                    // Pending write first so a write landing on this very cycle wins.
                    if (pend_valid_q) gain_q[pend_addr_q] <= pend_data_q;
                    if (gain_write_i && addr_ok) gain_q[gain_addr_i] <= gain_wrdata_i;
                    pend_valid_q <= 1'b0;
                end
                default: ;
            endcase
            if (gain_write_i && addr_ok && (state_q == StMac || state_q == StSat)) begin
                pend_valid_q <= 1'b1;
                pend_addr_q  <= gain_addr_i;
                pend_data_q  <= gain_wrdata_i;
            end
        end
    end

`ifdef AUDIO_MIXER_PEAK_EN
    logic [OUT_W-2:0] peak_l_q, peak_r_q;

    // Magnitude of the most negative value saturates to the largest positive one.
    function automatic logic [OUT_W-2:0] mag(input logic signed [OUT_W-1:0] v);
        logic signed [OUT_W-1:0] n;
        n = -v;
        if (!v[OUT_W-1])     return v[OUT_W-2:0];
        else if (n[OUT_W-1]) return '1;
        else                 return n[OUT_W-2:0];
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else if (peak_clear_i) begin
            peak_l_q <= out_valid_q ? mag(left_out_q) : '0;
            peak_r_q <= out_valid_q ? mag(right_out_q) : '0;
        end else if (out_valid_q) begin
            if (mag(left_out_q) > peak_l_q)  peak_l_q <= mag(left_out_q);
            if (mag(right_out_q) > peak_r_q) peak_r_q <= mag(right_out_q);
        end
    end

    assign peak_l_o = peak_l_q;
    assign peak_r_o = peak_r_q;
`endif

    assign gain_rddata_o = addr_ok ? gain_q[gain_addr_i] : '0;
    assign left_out_o    = left_out_q;
    assign right_out_o   = right_out_q;
    assign out_valid_o   = out_valid_q;
    assign busy_o        = (state_q != StIdle);
    assign clip_l_o      = clip_l_q;
    assign clip_r_o      = clip_r_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed self-checking bench for audio_mixer (default parameters).
module tb_audio_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        next_sample;
    logic [63:0] ch_left, ch_right;
    logic [1:0]  gain_addr;
    logic [7:0]  gain_wrdata;
    logic        gain_write;
    logic [7:0]  gain_rddata;
    logic        master_mute, clip_clear;
    logic [23:0] left_out, right_out;
    logic        out_valid, busy, clip_l, clip_r, overrun;
`ifdef AUDIO_MIXER_PEAK_EN
    logic        peak_clear;
    logic [22:0] peak_l, peak_r;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    audio_mixer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .next_sample_i (next_sample),
        .ch_left_i     (ch_left),
        .ch_right_i    (ch_right),
        .gain_addr_i   (gain_addr),
        .gain_wrdata_i (gain_wrdata),
        .gain_write_i  (gain_write),
        .gain_rddata_o (gain_rddata),
        .master_mute_i (master_mute),
        .clip_clear_i  (clip_clear),
        .left_out_o    (left_out),
        .right_out_o   (right_out),
        .out_valid_o   (out_valid),
        .busy_o        (busy),
        .clip_l_o      (clip_l),
        .clip_r_o      (clip_r),
`ifdef AUDIO_MIXER_PEAK_EN
        .peak_clear_i  (peak_clear),
        .peak_l_o      (peak_l),
        .peak_r_o      (peak_r),
`endif
        .overrun_o     (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_l(input logic [15:0] v);
        for (int i = 0; i < 4; i++) ch_left[i*16 +: 16] = v;
    endtask

    task automatic start_frame();
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
    endtask

    // Returns cycles from strobe to out_valid, or -1 if the bound expires.
    task automatic wait_valid(output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (n < 20 && lat < 0) begin
            tick();
            n++;
            if (out_valid === 1'b1) lat = n + 1;
        end
    endtask

    task automatic write_gain(input logic [1:0] a, input logic [7:0] d);
        gain_addr   = a;
        gain_wrdata = d;
        gain_write  = 1'b1;
        tick();
        gain_write  = 1'b0;
    endtask

    task automatic pulse_clip_clear();
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({left_out, right_out} !== 48'h0)
            $display("FAIL reset_out: got %h/%h want 0/0", left_out, right_out);
        else passed++;
        total++;
        if ({out_valid, busy, clip_l, clip_r, overrun} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {out_valid, busy, clip_l, clip_r, overrun});
        else passed++;
        for (int a = 0; a < 4; a++) begin
            gain_addr = a[1:0];
            #1;
            total++;
            if (gain_rddata !== 8'd128)
                $display("FAIL reset_gain%0d: got %0d want 128", a, gain_rddata);
            else passed++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int lat;
        ch_left  = '0;
        ch_right = '0;
        ch_left[15:0] = 16'h1000;
        start_frame();
        total++;
        if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy);
        else passed++;
        wait_valid(lat);
        total++;
        if (lat != 7) $display("FAIL single_latency: got %0d want 7", lat);
        else passed++;
        total++;
        if (left_out !== 24'h080000 || right_out !== 24'h0)
            $display("FAIL single_out: got %h/%h want 080000/000000", left_out, right_out);
        else passed++;
        total++;
        if ({clip_l, clip_r} !== 2'b00) $display("FAIL single_clip: got %b want 00", {clip_l, clip_r});
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || left_out !== 24'h080000)
            $display("FAIL single_hold: got v=%b b=%b l=%h want v=0 b=0 l=080000",
                     out_valid, busy, left_out);
        else passed++;
    endtask

    task automatic test_saturation();
        int lat;
        set_all_l(16'h7FFF);
        start_frame();
        wait_valid(lat);
        total++;
        if (lat != 7 || left_out !== 24'h7FFF80)
            $display("FAIL sat_pos: got lat=%0d l=%h want lat=7 l=7fff80", lat, left_out);
        else passed++;
        tick();
        tick();
        total++;
        if ({clip_l, clip_r} !== 2'b10) $display("FAIL sat_pos_clip: got %b want 10", {clip_l, clip_r});
        else passed++;
        pulse_clip_clear();
        total++;
        if (clip_l !== 1'b0) $display("FAIL sat_clear: got %b want 0", clip_l);
        else passed++;
        set_all_l(16'h8000);
        start_frame();
        wait_valid(lat);
        total++;
        if (left_out !== 24'h800000 || clip_l !== 1'b1)
            $display("FAIL sat_neg: got l=%h clip=%b want 800000 1", left_out, clip_l);
        else passed++;
        pulse_clip_clear();
        ch_left = '0;
    endtask

    task automatic test_gain();
        int lat;
        ch_left  = '0;
        ch_right = '0;
        ch_right[31:16] = 16'h4000;
        write_gain(2'd1, 8'd64);
        total++;
        if (gain_rddata !== 8'd64) $display("FAIL gain_rd64: got %0d want 64", gain_rddata);
        else passed++;
        start_frame();
        wait_valid(lat);
        total++;
        if (right_out !== 24'h100000) $display("FAIL gain_64: got %h want 100000", right_out);
        else passed++;
        write_gain(2'd1, 8'd0);
        total++;
        if (gain_rddata !== 8'd0) $display("FAIL gain_rd0: got %0d want 0", gain_rddata);
        else passed++;
        start_frame();
        wait_valid(lat);
        total++;
        if (right_out !== 24'h0) $display("FAIL gain_0: got %h want 000000", right_out);
        else passed++;
        ch_right = '0;
    endtask

    task automatic test_reset_midframe();
        int cnt;
        ch_left[15:0] = 16'h1000;
        start_frame();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || right_out !== 24'h0 || left_out !== 24'h0)
            $display("FAIL midreset_state: got b=%b l=%h want b=0 l=000000", busy, left_out);
        else passed++;
        gain_addr = 2'd1;
        #1;
        total++;
        if (gain_rddata !== 8'd128) $display("FAIL midreset_gain: got %0d want 128", gain_rddata);
        else passed++;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid === 1'b1) cnt++;
        end
        total++;
        if (cnt != 0) $display("FAIL midreset_valid: got %0d pulses want 0", cnt);
        else passed++;
    endtask

    task automatic test_pending_gain();
        int lat;
        ch_left = '0;
        ch_left[15:0] = 16'h1000;
        start_frame();
        tick();
        gain_addr   = 2'd0;
        gain_wrdata = 8'd0;
        gain_write  = 1'b1;
        tick();
        gain_write  = 1'b0;
        total++;
        if (gain_rddata !== 8'd128) $display("FAIL pend_rd_busy: got %0d want 128", gain_rddata);
        else passed++;
        wait_valid(lat);
        total++;
        if (lat < 0 || left_out !== 24'h080000)
            $display("FAIL pend_frame: got lat=%0d l=%h want l=080000", lat, left_out);
        else passed++;
        total++;
        if (gain_rddata !== 8'd0) $display("FAIL pend_commit: got %0d want 0", gain_rddata);
        else passed++;
        start_frame();
        wait_valid(lat);
        total++;
        if (left_out !== 24'h0) $display("FAIL pend_next: got %h want 000000", left_out);
        else passed++;
        write_gain(2'd0, 8'd128);
    endtask

    task automatic test_overrun();
        int cnt;
        ch_left = '0;
        ch_left[15:0] = 16'h1000;
        start_frame();
        cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 3) next_sample = 1'b1;
            tick();
            next_sample = 1'b0;
            if (out_valid === 1'b1) cnt++;
        end
        total++;
        if (cnt != 1) $display("FAIL ovr_pulses: got %0d want 1", cnt);
        else passed++;
        total++;
        if (overrun !== 1'b1 || left_out !== 24'h080000)
            $display("FAIL ovr_flag: got ovr=%b l=%h want 1 080000", overrun, left_out);
        else passed++;
        pulse_clip_clear();
        total++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] vin [3];
        logic [23:0] vexp [3];
        vin  = '{16'h1000, 16'h0800, 16'hE000};
        vexp = '{24'h080000, 24'h040000, 24'hF00000};
        ch_left = '0;
        ch_left[15:0] = vin[0];
        start_frame();
        for (int f = 0; f < 3; f++) begin
            wait_valid(lat);
            total++;
            if (lat != 7 || left_out !== vexp[f])
                $display("FAIL b2b_%0d: got lat=%0d l=%h want lat=7 l=%h", f, lat, left_out, vexp[f]);
            else passed++;
            if (f < 2) begin
                ch_left[15:0] = vin[f+1];
                start_frame();
            end
        end
        total++;
        if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun);
        else passed++;
    endtask

    task automatic test_mute();
        int lat;
        pulse_clip_clear();
        set_all_l(16'h7FFF);
        master_mute = 1'b1;
        start_frame();
        wait_valid(lat);
        total++;
        if (lat != 7 || left_out !== 24'h0 || clip_l !== 1'b0)
            $display("FAIL mute: got lat=%0d l=%h clip=%b want 7 000000 0", lat, left_out, clip_l);
        else passed++;
        master_mute = 1'b0;
        ch_left = '0;
    endtask

`ifdef AUDIO_MIXER_PEAK_EN
    task automatic test_peak();
        int lat;
        peak_clear = 1'b1;
        tick();
        peak_clear = 1'b0;
        ch_left = '0;
        ch_left[15:0] = 16'h1000;
        start_frame();
        wait_valid(lat);
        tick();
        total++;
        if (peak_l !== 23'h080000) $display("FAIL peak_pos: got %h want 080000", peak_l);
        else passed++;
        ch_left[15:0] = 16'hE000;
        start_frame();
        wait_valid(lat);
        tick();
        total++;
        if (peak_l !== 23'h100000) $display("FAIL peak_neg: got %h want 100000", peak_l);
        else passed++;
        peak_clear = 1'b1;
        tick();
        peak_clear = 1'b0;
        total++;
        if (peak_l !== 23'h0) $display("FAIL peak_clear: got %h want 000000", peak_l);
        else passed++;
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        next_sample = 1'b0;
        ch_left     = '0;
        ch_right    = '0;
        gain_addr   = '0;
        gain_wrdata = '0;
        gain_write  = 1'b0;
        master_mute = 1'b0;
        clip_clear  = 1'b0;
`ifdef AUDIO_MIXER_PEAK_EN
        peak_clear  = 1'b0;
`endif
        test_reset();
        test_single();
        test_saturation();
        test_gain();
        test_reset_midframe();
        test_pending_gain();
        test_overrun();
        test_back_to_back();
        test_mute();
`ifdef AUDIO_MIXER_PEAK_EN
        test_peak();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
